axis_data_width_upsizer: RTL and testbench
==========================================

Name: axis_data_width_upsizer

Overview:
Narrow-to-wide AXI-Stream width converter. It is the inverse of the packet-path downsizer: it packs consecutive narrow beats, IN_TDATA_WIDTH bits each, into one wide beat of OUT_TDATA_WIDTH bits. It sits at the exit of narrow-datapath processing stages and restores the 256-bit switch datapath. Packet boundaries are preserved, and a short final word is flushed on tlast with its unused lanes' tkeep cleared.

Parameters:
IN_TDATA_WIDTH, 64, narrow input data width; must be a multiple of 8.
OUT_TDATA_WIDTH, IN_TDATA_WIDTH*4, wide output data width; must be an integer multiple of IN_TDATA_WIDTH.
TUSER_WIDTH, 128, sideband metadata width.
RATIO (localparam), OUT_TDATA_WIDTH/IN_TDATA_WIDTH, narrow beats per wide beat.
IN_TKEEP_WIDTH / OUT_TKEEP_WIDTH (localparams), data width / 8.

Ports:
axis_aclk  in  1  single clock.
axis_reset  in  1  synchronous, active-high reset.
axis_original_tdata  in  IN_TDATA_WIDTH  narrow data.
axis_original_tkeep  in  IN_TKEEP_WIDTH  narrow byte enables.
axis_original_tuser  in  TUSER_WIDTH  metadata; meaningful on first beat of packet.
axis_original_tvalid  in  1  narrow beat valid.
axis_original_tready  out  1  narrow beat accepted when high with tvalid.
axis_original_tlast  in  1  last narrow beat of packet.
axis_resize_tdata  out  OUT_TDATA_WIDTH  packed wide data.
axis_resize_tkeep  out  OUT_TKEEP_WIDTH  packed byte enables.
axis_resize_tuser  out  TUSER_WIDTH  tuser of first narrow beat of this wide word.
axis_resize_tvalid  out  1  wide beat valid.
axis_resize_tready  in  1  downstream ready.
axis_resize_tlast  out  1  wide beat ends packet.

Behaviour:
- State: lane counter cnt (0..RATIO-1), accumulator acc_data/acc_keep/acc_user, and a registered output stage out_* with out_valid.
- Reset (synchronous, axis_reset=1 at posedge):
  - cnt=0; acc_* = 0; out_valid=0; all axis_resize_* outputs = 0.
  - axis_original_tready is 0 while reset is asserted.
  - Reset mid-packet discards any partial word and any pending output word.
- Ready:
  - axis_original_tready = !out_valid || axis_resize_tready.
  - This is combinational from downstream ready, with no path from tvalid.
- Accept: a narrow beat is accepted when axis_original_tvalid && axis_original_tready.
- Lane placement: beat at lane cnt goes to data[cnt*IN_TDATA_WIDTH +: IN_TDATA_WIDTH] and keep[cnt*IN_TKEEP_WIDTH +: IN_TKEEP_WIDTH]. Lane 0 is the least-significant lane (little-endian, matching the downsizer).
- tuser: captured only when cnt==0.
- Non-completing accept (cnt<RATIO-1 and tlast=0): write the lane into acc; cnt<=cnt+1.
- Completing accept (cnt==RATIO-1 or tlast=1):
  - On the next cycle, out_data = acc with the current beat merged in.
  - out_keep has lanes above cnt forced to 0, and out_tlast = input tlast.
  - out_valid<=1; acc_keep<=0; cnt<=0.
- Latency: the wide word is valid 1 cycle after its completing narrow beat is accepted. Throughput is 1 narrow beat per cycle.
- Output: out_* hold stable while out_valid && !axis_resize_tready (AXIS rule).
  - On handshake with no new completion, out_valid<=0.
  - Handshake and new completion in the same cycle: the new word loads and out_valid stays 1.
- Back-pressure: while out_valid && !axis_resize_tready, input tready=0, so the accumulator is frozen.
- tlast on lane 0: emits a wide word containing only lane 0 (keep = lane0 keep, all else 0).
- RATIO==1: acts as a registered one-deep pipe stage.
- Input beats with tkeep all zero are packed as given, with no compaction.
- Illegal parameters (non-integer RATIO): elaboration-time error via generate-time check.

Decomposition:
- Shared package axis_pkg holds:
  - the clog2 constant function used for the cnt width;
  - a common RATIO/lane-index derivation, shared with the downsizer.
- No sub-module. Accumulator, counter and output register are inline; the block is ~150-200 lines.

Test Plan:
- Full packet: 8 beats of 64b, tkeep=0xFF, tlast on beat 8, tready=1 → exactly 2 wide beats. Word0 = {b3,b2,b1,b0} with tkeep=0xFFFFFFFF and tlast=0. Word1 = {b7..b4} with tlast=1.
- Short tail: 5 beats, last tkeep=0x0F → word1 keeps lane0 only: tkeep=0x0000000F, tlast=1, upper data lanes don't-care.
- Single-beat packet: 1 beat, tlast=1, tuser=0xABCD → 1 wide beat, tkeep=0x000000FF, tuser=0xABCD, valid 1 cycle after accept.
- Back-pressure: hold axis_resize_tready=0 for 10 cycles with a word pending → output bits stable, axis_original_tready=0. Release → no beat lost or duplicated; a back-to-back 64-packet random test matches the scoreboard.
- tuser capture: packet of 8 beats with tuser incrementing per beat → word0.tuser = beat0 tuser, word1.tuser = beat4 tuser.
- Reset mid-packet: accept 2 beats, then assert axis_reset for 1 cycle → outputs 0 and cnt=0. The next full packet emits correctly aligned words with no stale lanes.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-Stream width-conversion helpers.
// Used by the upsizer (and the matching downsizer) to derive the lane ratio
// and the lane-counter width from the narrow/wide data widths.
package axis_pkg;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of narrow lanes carried by one wide beat.
    function automatic int unsigned width_ratio(input int unsigned narrow_width,
                                                input int unsigned wide_width);
        return wide_width / narrow_width;
    endfunction

    // Width of a lane index; at least one bit so RATIO==1 still has a counter.
    function automatic int unsigned lane_index_width(input int unsigned ratio);
        return (ratio > 1) ? clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/axis_data_width_upsizer.sv
// Narrow-to-wide AXI-Stream width converter.
// Packs RATIO consecutive narrow beats (lane 0 = least-significant) into one
// wide beat. A tlast beat flushes a partial word with unused lanes' tkeep
// cleared. tuser of the first narrow beat of each wide word is forwarded.
//
// Ports:
//   axis_aclk / axis_reset      : clock, synchronous active-high reset
//   axis_original_*             : narrow input stream (tdata/tkeep/tuser/tvalid/tready/tlast)
//   axis_resize_*               : wide output stream (tdata/tkeep/tuser/tvalid/tready/tlast)
module axis_data_width_upsizer
    import axis_pkg::*;
#(
    parameter int IN_TDATA_WIDTH  = 64,
    parameter int OUT_TDATA_WIDTH = IN_TDATA_WIDTH * 4,
    parameter int TUSER_WIDTH     = 128,
    localparam int IN_TKEEP_WIDTH  = IN_TDATA_WIDTH / 8,
    localparam int OUT_TKEEP_WIDTH = OUT_TDATA_WIDTH / 8
) (
    input  logic                       axis_aclk,
    input  logic                       axis_reset,

    input  logic [IN_TDATA_WIDTH-1:0]  axis_original_tdata,
    input  logic [IN_TKEEP_WIDTH-1:0]  axis_original_tkeep,
    input  logic [TUSER_WIDTH-1:0]     axis_original_tuser,
    input  logic                       axis_original_tvalid,
    output logic                       axis_original_tready,
    input  logic                       axis_original_tlast,

    output logic [OUT_TDATA_WIDTH-1:0] axis_resize_tdata,
    output logic [OUT_TKEEP_WIDTH-1:0] axis_resize_tkeep,
    output logic [TUSER_WIDTH-1:0]     axis_resize_tuser,
    output logic                       axis_resize_tvalid,
    input  logic                       axis_resize_tready,
    output logic                       axis_resize_tlast
);

    localparam int unsigned RATIO = width_ratio(IN_TDATA_WIDTH, OUT_TDATA_WIDTH);
    localparam int unsigned CNT_W = lane_index_width(RATIO);

    if (((IN_TDATA_WIDTH % 8) != 0) || ((OUT_TDATA_WIDTH % IN_TDATA_WIDTH) != 0)) begin : g_bad_params
        $error("axis_data_width_upsizer: widths must be byte multiples with an integer ratio");
    end

    logic [CNT_W-1:0]           cnt;
    logic [OUT_TDATA_WIDTH-1:0] acc_data;
    logic [OUT_TKEEP_WIDTH-1:0] acc_keep;
    logic [TUSER_WIDTH-1:0]     acc_user;

    logic [OUT_TDATA_WIDTH-1:0] out_data;
    logic [OUT_TKEEP_WIDTH-1:0] out_keep;
    logic [TUSER_WIDTH-1:0]     out_user;
    logic                       out_last;
    logic                       out_valid;

    logic [OUT_TDATA_WIDTH-1:0] merged_data;
    logic [OUT_TKEEP_WIDTH-1:0] merged_keep;
    logic [OUT_TKEEP_WIDTH-1:0] flush_keep;
    logic                       accept;
    logic                       last_lane;
    logic                       complete;

    // Ready depends only on the output stage and downstream ready, never on tvalid.
    assign axis_original_tready = !axis_reset && (!out_valid || axis_resize_tready);
    assign accept    = axis_original_tvalid && axis_original_tready;
    assign last_lane = (cnt == CNT_W'(RATIO - 1));
    assign complete  = last_lane || axis_original_tlast;

    // Accumulator with the current beat written into lane cnt; flush_keep
    // additionally clears every lane above cnt for a short final word.
    always_comb begin
        merged_data = acc_data;
        merged_keep = acc_keep;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (i == 32'(cnt)) begin
                merged_data[i*IN_TDATA_WIDTH +: IN_TDATA_WIDTH] = axis_original_tdata;
                merged_keep[i*IN_TKEEP_WIDTH +: IN_TKEEP_WIDTH] = axis_original_tkeep;
            end
        end
        flush_keep = merged_keep;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (i > 32'(cnt)) begin
                flush_keep[i*IN_TKEEP_WIDTH +: IN_TKEEP_WIDTH] = '0;
            end
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            cnt       <= '0;
            acc_data  <= '0;
            acc_keep  <= '0;
            acc_user  <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_user  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && axis_resize_tready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (cnt == '0) begin
                    acc_user <= axis_original_tuser;
                end
                if (complete) begin
                    // A completion in the same cycle as a handshake overrides the clear above.
                    out_data  <= merged_data;
                    out_keep  <= flush_keep;
                    out_user  <= (cnt == '0) ? axis_original_tuser : acc_user;
                    out_last  <= axis_original_tlast;
                    out_valid <= 1'b1;
                    acc_keep  <= '0;
                    cnt       <= '0;
                end else begin
                    acc_data <= merged_data;
                    acc_keep <= merged_keep;
                    cnt      <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign axis_resize_tdata  = out_data;
    assign axis_resize_tkeep  = out_keep;
    assign axis_resize_tuser  = out_user;
    assign axis_resize_tvalid = out_valid;
    assign axis_resize_tlast  = out_last;

endmodule

// File: tb/tb_axis_data_width_upsizer.sv
// Directed and scoreboard bench for axis_data_width_upsizer (64b -> 256b).
module tb_axis_data_width_upsizer;

    localparam int IW = 64;
    localparam int OW = 256;
    localparam int UW = 128;

    logic          clk;
    logic          rst;
    logic [IW-1:0] i_data;
    logic [7:0]    i_keep;
    logic [UW-1:0] i_user;
    logic          i_valid;
    logic          i_ready;
    logic          i_last;
    logic [OW-1:0] o_data;
    logic [31:0]   o_keep;
    logic [UW-1:0] o_user;
    logic          o_valid;
    logic          o_ready;
    logic          o_last;

    axis_data_width_upsizer #(
        .IN_TDATA_WIDTH (IW),
        .OUT_TDATA_WIDTH(OW),
        .TUSER_WIDTH    (UW)
    ) dut (
        .axis_aclk           (clk),
        .axis_reset          (rst),
        .axis_original_tdata (i_data),
        .axis_original_tkeep (i_keep),
        .axis_original_tuser (i_user),
        .axis_original_tvalid(i_valid),
        .axis_original_tready(i_ready),
        .axis_original_tlast (i_last),
        .axis_resize_tdata   (o_data),
        .axis_resize_tkeep   (o_keep),
        .axis_resize_tuser   (o_user),
        .axis_resize_tvalid  (o_valid),
        .axis_resize_tready  (o_ready),
        .axis_resize_tlast   (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic          v;
        logic [IW-1:0] d;
        logic [7:0]    k;
        logic [UW-1:0] u;
        logic          l;
        logic          rr;
        logic          e_irdy;
        logic          e_ov;
        logic [OW-1:0] e_od;
        logic [31:0]   e_ok;
        logic [UW-1:0] e_ou;
        logic          e_ol;
    } vec_t;

    typedef struct {
        logic [OW-1:0] d;
        logic [31:0]   k;
        logic [UW-1:0] u;
        logic          l;
    } word_t;

    typedef struct {
        logic [IW-1:0] d;
        logic [7:0]    k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    vec_t  vecs[$];
    word_t sb[$];
    beat_t beats[$];

    function automatic logic [IW-1:0] bd(input int n);
        return {32'(32'hC0DE_0000 + n), 32'(32'h0B0E_0000 + n)};
    endfunction

    function automatic logic [UW-1:0] uu(input int n);
        return 128'h5000 + 128'(n);
    endfunction

    function automatic vec_t mk(input logic v, input logic [IW-1:0] d, input logic [7:0] k,
                                input logic [UW-1:0] u, input logic l, input logic rr,
                                input logic e_irdy, input logic e_ov, input logic [OW-1:0] e_od,
                                input logic [31:0] e_ok, input logic [UW-1:0] e_ou, input logic e_ol);
        vec_t r;
        r.v = v; r.d = d; r.k = k; r.u = u; r.l = l; r.rr = rr;
        r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_od = e_od; r.e_ok = e_ok; r.e_ou = e_ou; r.e_ol = e_ol;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Data compared only on bytes whose expected tkeep bit is set.
    task automatic chk_word(input string nm, input logic [OW-1:0] ed, input logic [31:0] ek,
                            input logic [UW-1:0] eu, input logic el);
        logic [OW-1:0] mask;
        mask = '0;
        for (int b = 0; b < 32; b++) begin
            if (ek[b]) mask[b*8 +: 8] = 8'hFF;
        end
        chk({nm, ".data"}, o_data & mask, ed & mask);
        chk({nm, ".keep"}, OW'(o_keep), OW'(ek));
        chk({nm, ".user"}, OW'(o_user), OW'(eu));
        chk({nm, ".last"}, OW'(o_last), OW'(el));
    endtask

    task automatic drive(input logic v, input logic [IW-1:0] d, input logic [7:0] k,
                         input logic [UW-1:0] u, input logic l, input logic rr);
        i_valid = v; i_data = d; i_keep = k; i_user = u; i_last = l; o_ready = rr;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [OW-1:0] m_data;
    logic [31:0]   m_keep;
    logic [UW-1:0] m_user;
    int            m_lane;

    task automatic model_accept(input beat_t b);
        word_t w;
        m_data[m_lane*IW +: IW] = b.d;
        m_keep[m_lane*8 +: 8]   = b.k;
        if (m_lane == 0) m_user = b.u;
        if (m_lane == 3 || b.l) begin
            w.d = m_data; w.k = m_keep; w.u = m_user; w.l = b.l;
            sb.push_back(w);
            m_lane = 0; m_data = '0; m_keep = '0;
        end else begin
            m_lane++;
        end
    endtask

    initial begin
        int idx;
        int cycles;
        beat_t bt;
        word_t w;
        logic  v;
        logic  rr;

        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        rst = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst.tready", OW'(i_ready), OW'(0));
        step();
        chk("rst.valid", OW'(o_valid), OW'(0));
        chk("rst.tdata", o_data, '0);
        chk("rst.tkeep", OW'(o_keep), OW'(0));
        rst = 1'b0;
        #1;
        chk("post_rst.tready", OW'(i_ready), OW'(1));
        @(negedge clk);

        // Cycle-by-cycle directed table
        vecs.push_back(mk(1, bd(0), 8'hFF, uu(0), 0, 1, 1, 0, '0, '0, '0, 0));
        vecs.push_back(mk(1, bd(1), 8'hFF, uu(1), 0, 1, 1, 0, '0, '0, '0, 0));
        vecs.push_back(mk(1, bd(2), 8'hFF, uu(2), 0, 1, 1, 0, '0, '0, '0, 0));
        vecs.push_back(mk(1, bd(3), 8'hFF, uu(3), 0, 1, 1, 1, {bd(3), bd(2), bd(1), bd(0)}, 32'hFFFF_FFFF, uu(0), 0));
        vecs.push_back(mk(1, bd(4), 8'hFF, uu(4), 0, 1, 1, 0, '0, '0, '0, 0));
        vecs.push_back(mk(1, bd(5), 8'hFF, uu(5), 0, 1, 1, 0, '0, '0, '0, 0));
        vecs.push_back(mk(1, bd(6), 8'hFF, uu(6), 0, 1, 1, 0, '0, '0, '0, 0));
        vecs.push_back(mk(1, bd(7), 8'hFF, uu(7), 1, 1, 1, 1, {bd(7), bd(6), bd(5), bd(4)}, 32'hFFFF_FFFF, uu(4), 1));
        vecs.push_back(mk(1, bd(8), 8'hFF, uu(8), 0, 1, 1, 0, '0, '0, '0, 0));
        vecs.push_back(mk(1, bd(9), 8'hFF, uu(9), 0, 1, 1, 0, '0, '0, '0, 0));
        vecs.push_back(mk(1, bd(10), 8'hFF, uu(10), 0, 1, 1, 0, '0, '0, '0, 0));
        vecs.push_back(mk(1, bd(11), 8'hFF, uu(11), 0, 1, 1, 1, {bd(11), bd(10), bd(9), bd(8)}, 32'hFFFF_FFFF, uu(8), 0));
        vecs.push_back(mk(1, bd(12), 8'h0F, uu(12), 1, 1, 1, 1, {192'h0, bd(12)}, 32'h0000_000F, uu(12), 1));
        vecs.push_back(mk(1, bd(13), 8'hFF, 128'hABCD, 1, 1, 1, 1, {192'h0, bd(13)}, 32'h0000_00FF, 128'hABCD, 1));
        vecs.push_back(mk(0, '0, '0, '0, 0, 1, 1, 0, '0, '0, '0, 0));
        vecs.push_back(mk(1, bd(15), 8'h00, uu(15), 0, 1, 1, 0, '0, '0, '0, 0));
        vecs.push_back(mk(1, bd(16), 8'hFF, uu(16), 1, 1, 1, 1, {128'h0, bd(16), bd(15)}, 32'h0000_FF00, uu(15), 1));
        vecs.push_back(mk(0, '0, '0, '0, 0, 1, 1, 0, '0, '0, '0, 0));
        vecs.push_back(mk(0, '0, '0, '0, 0, 0, 1, 0, '0, '0, '0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].k, vecs[i].u, vecs[i].l, vecs[i].rr);
            #1;
            chk($sformatf("vec%0d.tready", i), OW'(i_ready), OW'(vecs[i].e_irdy));
            step();
            chk($sformatf("vec%0d.valid", i), OW'(o_valid), OW'(vecs[i].e_ov));
            if (vecs[i].e_ov)
                chk_word($sformatf("vec%0d", i), vecs[i].e_od, vecs[i].e_ok, vecs[i].e_ou, vecs[i].e_ol);
        end

        // Back-pressure: pending word held for 10 cycles, input stalled
        drive(1, bd(20), 8'hFF, uu(20), 1, 0);
        step();
        chk("bp.valid", OW'(o_valid), OW'(1));
        chk_word("bp.first", {192'h0, bd(20)}, 32'h0000_00FF, uu(20), 1);
        drive(1, bd(21), 8'hFF, uu(21), 1, 0);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("bp%0d.tready", c), OW'(i_ready), OW'(0));
            step();
            chk($sformatf("bp%0d.valid", c), OW'(o_valid), OW'(1));
            chk_word($sformatf("bp%0d.hold", c), {192'h0, bd(20)}, 32'h0000_00FF, uu(20), 1);
        end
        o_ready = 1'b1;
        #1;
        chk("bp_rel.tready", OW'(i_ready), OW'(1));
        step();
        chk("bp_rel.valid", OW'(o_valid), OW'(1));
        chk_word("bp_rel.next", {192'h0, bd(21)}, 32'h0000_00FF, uu(21), 1);
        drive(0, '0, '0, '0, 0, 1);
        step();
        chk("bp_drain.valid", OW'(o_valid), OW'(0));

        // Reset mid-packet discards the partial word
        drive(1, bd(40), 8'hFF, uu(40), 0, 1);
        step();
        drive(1, bd(41), 8'hFF, uu(41), 0, 1);
        step();
        drive(1, bd(42), 8'hFF, uu(42), 0, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst.tready", OW'(i_ready), OW'(0));
        step();
        rst = 1'b0;
        chk("mid_rst.valid", OW'(o_valid), OW'(0));
        chk("mid_rst.tdata", o_data, '0);
        chk("mid_rst.tkeep", OW'(o_keep), OW'(0));
        chk("mid_rst.tuser", OW'(o_user), OW'(0));
        chk("mid_rst.tlast", OW'(o_last), OW'(0));
        for (int b = 0; b < 4; b++) begin
            drive(1, bd(50 + b), 8'hFF, uu(50 + b), (b == 3), 1);
            step();
            chk($sformatf("after_rst%0d.valid", b), OW'(o_valid), OW'(b == 3));
        end
        chk_word("after_rst.word", {bd(53), bd(52), bd(51), bd(50)}, 32'hFFFF_FFFF, uu(50), 1);
        drive(0, '0, '0, '0, 0, 1);
        step();

        // Random back-to-back packets against a packing scoreboard
        for (int p = 0; p < 64; p++) begin
            int len;
            len = $urandom_range(1, 11);
            for (int b = 0; b < len; b++) begin
                bt.d = {$urandom, $urandom};
                bt.k = (b == len - 1) ? 8'($urandom_range(0, 255)) : 8'hFF;
                bt.u = {$urandom, $urandom, $urandom, $urandom};
                bt.l = (b == len - 1);
                beats.push_back(bt);
            end
        end
        m_lane = 0; m_data = '0; m_keep = '0; m_user = '0;
        idx = 0;
        cycles = 0;
        while ((idx < beats.size() || sb.size() > 0 || o_valid) && cycles < 20000) begin
            v  = (idx < beats.size()) && ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            if (v) drive(1, beats[idx].d, beats[idx].k, beats[idx].u, beats[idx].l, rr);
            else   drive(0, '0, '0, '0, 0, rr);
            #1;
            if (o_valid && rr) begin
                if (sb.size() == 0) begin
                    chk("rand.extra_word", OW'(o_valid), OW'(0));
                end else begin
                    w = sb.pop_front();
                    chk_word("rand", w.d, w.k, w.u, w.l);
                end
            end
            if (v && i_ready) begin
                model_accept(beats[idx]);
                idx++;
            end
            step();
            cycles++;
        end
        chk("rand.beats_sent", OW'(idx), OW'(beats.size()));
        chk("rand.words_left", OW'(sb.size()), OW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
